// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter
//
// Sends one command byte to a PS/2 device using the host-to-device
// request sequence. First it inhibits the clock. Then it requests to send
// by holding clock and data low. Then it releases the clock and shifts
// the data LSB first on each device falling clock edge. Last it checks
// the device ACK and waits until both lines are idle again.
//
// Ports:
//   CLOCK_50    system clock, rising edge only
//   reset_n     synchronous active-low reset
//   tx_data     byte to send
//   tx_valid    tx_data valid (sampled only in IDLE)
//   tx_ready    block can accept a byte
//   ps2_clk_in  raw PS2_CLK pad level
//   ps2_dat_in  raw PS2_DAT pad level
//   ps2_clk_oe  1 = pull PS2_CLK low
//   ps2_dat_oe  1 = pull PS2_DAT low
//   tx_done     one-cycle pulse, byte sent and acknowledged
//   tx_error    one-cycle pulse, missing ACK or watchdog timeout
//   busy        high whenever not IDLE

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);

    // Counters only ever reach PARAM-1, so $clog2(PARAM) bits suffice.
    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int REQ_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         clk_sync_q;
    logic [1:0]         dat_sync_q;
    logic               clk_prev_q;
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [REQ_W-1:0]   req_cnt_q, req_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               dat_drive_q, dat_drive_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               ready_en_q;

    logic               clk_s;
    logic               dat_s;
    logic               clk_fall;
    logic               wd_expired;

    assign clk_s      = clk_sync_q[1];
    assign dat_s      = dat_sync_q[1];
    assign clk_fall   = clk_prev_q & ~clk_s;
    assign wd_expired = (wd_cnt_q == WD_LAST);

    // ready_en_q holds tx_ready low through reset and releases it one cycle
    // after reset_n is first sampled high.
    assign tx_ready   = (state_q == S_IDLE) & ready_en_q;
    assign busy       = (state_q != S_IDLE);
    assign ps2_clk_oe = (state_q == S_INHIBIT) | (state_q == S_REQ);
    // The start bit is driven in REQ and then carried into SHIFT by
    // dat_drive_q until the first device falling edge.
    assign ps2_dat_oe = (state_q == S_REQ) | ((state_q == S_SHIFT) & dat_drive_q);
    assign tx_done    = done_q;
    assign tx_error   = error_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            data_q      <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            req_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            dat_drive_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q  <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q  <= clk_s;
            data_q      <= data_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            req_cnt_q   <= req_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            dat_drive_q <= dat_drive_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ready_en_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        req_cnt_d   = req_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        dat_drive_d = dat_drive_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    data_d      = tx_data;
                    parity_d    = ~^tx_data;
                    inh_cnt_d   = '0;
                    req_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    wd_cnt_d    = '0;
                    dat_drive_d = 1'b0;
                    state_d     = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    inh_cnt_d = '0;
                    req_cnt_d = '0;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            S_REQ: begin
                if (req_cnt_q == REQ_LAST) begin
                    req_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    wd_cnt_d    = '0;
                    dat_drive_d = 1'b1;
                    state_d     = S_SHIFT;
                end else begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (wd_expired) begin
                    error_d     = 1'b1;
                    dat_drive_d = 1'b0;
                    wd_cnt_d    = '0;
                    state_d     = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (clk_fall) begin
                        // bit_cnt_q counts edges already seen: 0..7 data,
                        // 8 parity, 9 stop (line released).
                        if (bit_cnt_q < 4'd8) begin
                            dat_drive_d = ~data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_drive_d = ~parity_q;
                        end else begin
                            dat_drive_d = 1'b0;
                            state_d     = S_ACK;
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_ACK: begin
                if (wd_expired) begin
                    error_d  = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (clk_fall) begin
                        if (!dat_s) begin
                            state_d = S_WAIT_IDLE;
                        end else begin
                            error_d  = 1'b1;
                            wd_cnt_d = '0;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (wd_expired) begin
                    error_d  = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = S_IDLE;
                end else if (clk_s && dat_s) begin
                    done_d   = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL provide parameter INHIBIT_CYCLES, default 5000, the clock-low inhibit time in CLOCK_50 cycles (100 us).
REQ-002 The block SHALL provide parameter REQ_CYCLES, default 50, the time both lines are held low before the clock is released.
REQ-003 The block SHALL provide parameter TIMEOUT_CYCLES, default 1000000, the transfer watchdog limit in cycles (20 ms).
REQ-004 CLOCK_50  input  1  system clock; all logic on its rising edge; the only clock.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 tx_data  input  8  command byte to send to the device.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  block can accept a byte.
REQ-009 ps2_clk_in  input  1  raw PS2_CLK pad level.
REQ-010 ps2_dat_in  input  1  raw PS2_DAT pad level.
REQ-011 ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (open-collector).
REQ-012 ps2_dat_oe  output  1  1 = drive PS2_DAT low, 0 = release.
REQ-013 tx_done  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-014 tx_error  output  1  one-cycle pulse: missing ACK or timeout.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 ps2_clk_in and ps2_dat_in SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected when the previous synchronized clock is 1 and the current is 0.
REQ-017 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-018 IDLE: tx_ready=1, both oe=0; tx_valid&tx_ready latches tx_data and computes odd parity (~^tx_data); next state INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-020 REQ: ps2_clk_oe=1, ps2_dat_oe=1 (start bit) for exactly REQ_CYCLES cycles, then SHIFT with ps2_clk_oe=0 and ps2_dat_oe held at 1.
REQ-021 SHIFT: on falling edges 1..8, ps2_dat_oe SHALL become the inverse of data bit 0..7 (LSB first); on edge 9, the inverse of parity; on edge 10, 0 (stop bit, line released); then ACK.
REQ-022 ACK: on the next falling edge, synchronized data 0 SHALL mean ACK OK, then WAIT_IDLE; data 1 SHALL pulse tx_error and return to IDLE.
REQ-023 WAIT_IDLE: once synchronized clock and data are both 1 in the same cycle, the block SHALL pulse tx_done and return to IDLE.
REQ-024 The watchdog SHALL count from SHIFT entry; reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE SHALL pulse tx_error, set both oe=0 and return to IDLE.
REQ-025 tx_done and tx_error SHALL never assert in the same cycle and SHALL be 0 outside their single pulse cycle.
REQ-026 tx_valid outside IDLE SHALL be ignored; tx_data changes after acceptance SHALL not affect the byte in flight.
REQ-027 Bit counter width SHALL be 4 bits; the inhibit, request and watchdog counters SHALL be sized by $clog2 of their parameters and SHALL not wrap.
REQ-028 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.

Reset
REQ-029 While reset_n=0 at a clock edge: state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=0, busy=0, tx_done=0, tx_error=0, synchronizers=1, all counters=0.
REQ-030 The cycle after reset_n is sampled 1, tx_ready SHALL be 1.
REQ-031 Reset asserted mid-transfer SHALL release both lines on the next edge, with no tx_done or tx_error pulse.

Verification
REQ-032 Send 0xED (INHIBIT_CYCLES=20, REQ_CYCLES=4) with the device model ACKing -> clk_oe high 20 cycles, then both oe high 4 cycles; data line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one tx_done pulse.
REQ-033 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; each ends with tx_done.
REQ-034 Device model leaves data high at the ACK edge -> one tx_error pulse, no tx_done, IDLE, tx_ready=1.
REQ-035 Device never clocks (TIMEOUT_CYCLES=100) -> tx_error exactly 100 cycles after SHIFT entry; both oe=0.
REQ-036 reset_n=0 after falling edge 5 -> both oe=0 next cycle, no pulse; a new 0xF4 transfer then completes with tx_done.
REQ-037 tx_valid held high during a transfer with tx_data changing -> only the first byte is sent; the second is accepted only after returning to IDLE.
